// File: rtl/round_robin_arbiter.sv
// ============================================================================
//  Module   : round_robin_arbiter
//  Purpose  : Round-robin arbiter with a registered one-hot grant, a binary
//             grant index and a rotating priority pointer. Each grant is held
//             until the grantee signals done, followed by one idle cycle.
//             Optional feature macro ARB_TIMEOUT_EN adds a hold counter that
//             forces a release (with a one-cycle timeout pulse) after MAX_HOLD
//             grant cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_robin_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [NUM_REQ-1:0] c_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Reject configurations whose index cannot address every requester or
    // whose hold limit would release before the first grant cycle completes.
    if ((IDX_W < $clog2(NUM_REQ)) || (IDX_W < 1) || (MAX_HOLD < 1)) begin : g_cfg_check
        $error("round_robin_arbiter: illegal NUM_REQ/IDX_W/MAX_HOLD combination");
    end

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic                 gnt_valid_q;

    logic                 win_found_d;
    logic [IDX_W-1:0]     win_idx_d;
    logic [IDX_W-1:0]     ptr_inc_d;
    logic [IDX_W:0]       cand_sum;
    logic [IDX_W:0]       inc_sum;

    // Winner search: scan offsets from the far end down to 0 so that the
    // requester closest to ptr (searching upward, wrapping) is written last.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand_sum[IDX_W-1:0]]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // Pointer value after a release: one past the current grantee, modulo NUM_REQ.
    always_comb begin
        inc_sum = {1'b0, gnt_idx_q} + {{IDX_W{1'b0}}, 1'b1};
        if (inc_sum >= (IDX_W+1)'(NUM_REQ)) begin
            inc_sum = '0;
        end
        ptr_inc_d = inc_sum[IDX_W-1:0];
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] hold_cnt_q;
    logic             timeout_q;

    // Arbiter state machine with hold counter; the counter is 0 on the first
    // grant cycle and an explicit done on the limit cycle wins over timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q     <= GRANT;
                        gnt_q       <= c_one << win_idx_d;
                        gnt_idx_q   <= win_idx_d;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end
                end
                GRANT: begin
                    if (done || (hold_cnt_q == CNT_W'(MAX_HOLD - 1))) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= ptr_inc_d;
                        hold_cnt_q  <= '0;
                        timeout_q   <= ~done;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout = timeout_q;
`else
    // Arbiter state machine: a grant is held until done, however long that takes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q     <= GRANT;
                        gnt_q       <= c_one << win_idx_d;
                        gnt_idx_q   <= win_idx_d;
                        gnt_valid_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (done) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= ptr_inc_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
// ============================================================================
//  Module   : tb_round_robin_arbiter
//  Purpose  : Self-checking bench for round_robin_arbiter. A vector table
//             drives the main arbitration behaviour; hand-written sequences
//             cover rotation, hold, timeout (ARB_TIMEOUT_EN) and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_robin_arbiter;

    localparam int NUM_REQ  = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic               done = 1'b0;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    round_robin_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of stimulus at a falling edge, queue the outputs expected
    // after the next rising edge, then pop and compare at the following falling edge.
    task automatic step(input logic [7:0] r, input logic d, input logic [7:0] eg,
                        input logic [2:0] ei, input logic ev, input logic et,
                        input string name);
        exp_t e;
        req     = r;
        done    = d;
        e.gnt   = eg;
        e.idx   = ei;
        e.valid = ev;
        e.to    = et;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || timeout !== e.to) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
                     name, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.to);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected all zero",
                     name, gnt, gnt_idx, gnt_valid, timeout);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[18];
        logic [7:0] one;
        one = 8'h01;

        // ptr starts at 0; comments give the pointer after each release.
        tbl[0]  = '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1}; // first grant, lowest index
        tbl[1]  = '{8'h05, 1'b1, 8'h00, 3'd0, 1'b0}; // release, ptr=1
        tbl[2]  = '{8'h05, 1'b0, 8'h04, 3'd2, 1'b1}; // search from 1 finds 2
        tbl[3]  = '{8'h05, 1'b0, 8'h04, 3'd2, 1'b1}; // held
        tbl[4]  = '{8'h00, 1'b0, 8'h04, 3'd2, 1'b1}; // grantee drops req, still held
        tbl[5]  = '{8'h05, 1'b1, 8'h00, 3'd2, 1'b0}; // release, idx kept, ptr=3
        tbl[6]  = '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1}; // wrap to 0
        tbl[7]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0}; // release, ptr=1
        tbl[8]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0}; // done in idle ignored
        tbl[9]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0}; // no requests
        tbl[10] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1}; // top requester
        tbl[11] = '{8'h80, 1'b1, 8'h00, 3'd7, 1'b0}; // release, ptr wraps to 0
        tbl[12] = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1}; // from 0 picks 0
        tbl[13] = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr=1
        tbl[14] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1}; // from 1 picks 7
        tbl[15] = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0}; // ptr=0
        tbl[16] = '{8'hFF, 1'b1, 8'h01, 3'd0, 1'b1}; // done in idle does not block grant
        tbl[17] = '{8'hFF, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr=1

        repeat (2) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].idx, tbl[i].valid, 1'b0,
                 $sformatf("vec%0d", i));
        end

        // Full rotation with every requester active, starting from a fresh pointer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0, one << (k % 8), 3'(k % 8), 1'b1, 1'b0, $sformatf("rr_grant%0d", k));
            step(8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0, $sformatf("rr_release%0d", k));
        end

        // Grant held while the request vanishes; ptr is 1 here.
        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "grant3");
        for (int k = 0; k < 10; k++) begin
            step(8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, $sformatf("hold3_%0d", k));
        end
        step(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "release3");

`ifdef ARB_TIMEOUT_EN
        // ptr=4: search wraps to 0. Grant cycles 2..16 hold, edge 16 forces release.
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "to_grant");
        for (int k = 0; k < MAX_HOLD - 1; k++) begin
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, $sformatf("to_hold%0d", k));
        end
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, "to_fire");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "to_pulse_end");
        // done on the limit cycle is an ordinary release.
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "tod_grant");
        for (int k = 0; k < MAX_HOLD - 1; k++) begin
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, $sformatf("tod_hold%0d", k));
        end
        step(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "tod_done_at_limit");
`else
        // Without the timeout feature a grant outlives any hold limit.
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "long_grant");
        for (int k = 0; k < 100; k++) begin
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, $sformatf("long_hold%0d", k));
        end
        step(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "long_release");
`endif

        // Asynchronous reset in the middle of a grant; ptr is 1 beforehand.
        step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "pre_reset_grant");
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset_immediate");
        @(negedge clk);
        check_idle("reset_held");
        rst = 1'b0;
        step(8'h82, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "post_reset_lowest");
        step(8'h82, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, "post_reset_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, the number of requesters.
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_REQ), the grant index width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, the maximum grant length in cycles; it is used only when ARB_TIMEOUT_EN is defined.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: request per requester, bit i = requester i.
REQ-007 The block SHALL have port done, input, 1 bit: the current grantee releases the resource.
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant, registered.
REQ-009 The block SHALL have port gnt_idx, output, IDX_W bits: binary index of the granted requester, registered.
REQ-010 The block SHALL have port gnt_valid, output, 1 bit: high while a grant is held.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-012 The block SHALL implement two states, IDLE and GRANT.
REQ-013 In IDLE with req nonzero, the block SHALL select a winner, enter GRANT, and drive gnt/gnt_idx/gnt_valid at the next rising edge (1-cycle latency).
REQ-014 Winner selection SHALL be the first asserted req bit searching upward from pointer ptr, wrapping from NUM_REQ-1 to 0.
REQ-015 In IDLE with req all-zero, the block SHALL stay in IDLE with gnt=0 and gnt_valid=0; gnt_idx holds its last value.
REQ-016 In GRANT, gnt, gnt_idx and gnt_valid SHALL be held constant regardless of req changes, including the grantee dropping its req.
REQ-017 When done=1 is sampled in GRANT, at that edge the block SHALL return to IDLE, clear gnt and gnt_valid, and set ptr=(gnt_idx+1) mod NUM_REQ.
REQ-018 After every release there SHALL be at least one IDLE cycle (gnt_valid=0) before the next grant.
REQ-019 done sampled in IDLE SHALL be ignored.
REQ-020 gnt SHALL be either zero or exactly one-hot, and gnt[gnt_idx]=1 SHALL hold whenever gnt_valid=1.
REQ-021 A single persistent requester SHALL be re-granted after each release, with ptr wrap-around handled.

Reset
REQ-022 Asserting rst SHALL immediately (asynchronously) force gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, state=IDLE, and the hold counter to 0.
REQ-023 rst asserted mid-grant SHALL drop the grant with no done and no timeout pulse.
REQ-024 After rst deasserts, the first grant SHALL go to the lowest-index requester.

Configuration
REQ-025 With macro ARB_TIMEOUT_EN defined, the block SHALL count cycles in GRANT (the counter is 0 on the first grant cycle).
REQ-026 With ARB_TIMEOUT_EN defined, if the counter reaches MAX_HOLD-1 with done=0, then at that edge the block SHALL release exactly as for done, assert timeout for one cycle, and advance ptr.
REQ-027 With ARB_TIMEOUT_EN defined, if done=1 coincides with the timeout cycle, the block SHALL treat it as a normal release with timeout=0.
REQ-028 With ARB_TIMEOUT_EN undefined, the block SHALL have no counter, timeout SHALL be tied to 0, and a grant SHALL be held until done indefinitely.

Verification
REQ-029 Scenario: after reset, req=8'b0000_0101 -> next cycle gnt=8'b0000_0001, gnt_idx=0, gnt_valid=1.
REQ-030 Scenario: keep req=8'b0000_0101 and pulse done -> one IDLE cycle, then gnt=8'b0000_0100, gnt_idx=2; after the next done -> gnt_idx=0 (wrap).
REQ-031 Scenario: req=8'hFF held, done pulsed after each grant -> gnt_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-032 Scenario: grant to requester 3, then req drops to 0 with done=0 for 10 cycles -> gnt stays 8'b0000_1000, gnt_valid=1.
REQ-033 Scenario (ARB_TIMEOUT_EN, MAX_HOLD=16): grant held with done=0 -> release on the 16th grant cycle, timeout=1 for exactly one cycle; without the macro the grant persists for 100 cycles with timeout=0.
REQ-034 Scenario: rst asserted mid-grant between clock edges -> gnt=0 and gnt_valid=0 immediately; after release, req=8'b1000_0010 -> gnt_idx=1.
